// File: rtl/instr_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_encoder : RV32I descriptor encoder streaming words into imem via FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_encoder #(
   parameter int ADDRESS_BITS = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] start_addr,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_class,
   input  logic [4:0]              in_rd,
   input  logic [4:0]              in_rs1,
   input  logic [4:0]              in_rs2,
   input  logic [2:0]              in_funct3,
   input  logic                    in_alt,
   input  logic [31:0]             in_imm,
   output logic                    mem_wEn,
   input  logic                    mem_ready,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic [31:0]             mem_wdata,
   output logic                    err,
   output logic [ADDRESS_BITS-1:0] count,
   output logic                    done
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t state, state_next;

   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full;
   logic             push, pop;
   logic [31:0]      enc_word;
   logic             enc_err;
   logic             fits_i12, fits_b13, fits_j21;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^start_addr[1:0];

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign in_ready  = (state == ST_RUN) && !fifo_full;
   assign push      = in_valid && in_ready;
   assign mem_wEn   = !fifo_empty;
   assign pop       = mem_wEn && mem_ready;
   assign mem_wdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[PTR_W-1:0]];
   assign done      = (state == ST_DONE);

   // Sign-extension checks: every bit above the field must equal the field's sign bit.
   assign fits_i12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign fits_b13 = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
   assign fits_j21 = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

   always_comb begin
      enc_word = NOP_WORD;
      enc_err  = 1'b0;
      case (in_class)
         4'd0: enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
         4'd1: begin
            if (in_funct3 == 3'b101) begin
               enc_word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
               enc_err  = |in_imm[31:5];
            end else begin
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
               enc_err  = !fits_i12;
            end
         end
         4'd2: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            enc_err  = !fits_i12;
         end
         4'd3: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            enc_err  = !fits_i12;
         end
         4'd4: begin
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_BRANCH};
            enc_err  = !fits_b13;
         end
         4'd5: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            enc_err  = !fits_j21;
         end
         4'd6: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
            enc_err  = !fits_i12;
         end
         4'd7: begin
            enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
            enc_err  = |in_imm[11:0];
         end
         4'd8: begin
            enc_word = {in_imm[31:12], in_rd, OP_LUI};
            enc_err  = |in_imm[11:0];
         end
         default: begin
            enc_word = NOP_WORD;
            enc_err  = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_RUN;
         ST_RUN:   if (flush) state_next = ST_DRAIN;
         ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_addr <= '0;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         state <= state_next;
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         if ((state == ST_IDLE) && start) begin
            mem_addr <= {start_addr[ADDRESS_BITS-1:2], 2'b00};
            count    <= '0;
            err      <= 1'b0;
         end else begin
            if (pop) begin
               mem_addr <= mem_addr + ADDRESS_BITS'(4);
               count    <= count + ADDRESS_BITS'(1);
            end
            if (push && enc_err) err <= 1'b1;
         end
      end
   end

   // Storage needs no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_encoder : scoreboard bench for instr_encoder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_encoder;

   localparam int AB = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AB-1:0] start_addr = '0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_class = '0;
   logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]    in_funct3 = '0;
   logic          in_alt = 1'b0;
   logic [31:0]   in_imm = '0;
   logic          mem_wEn;
   logic          mem_ready = 1'b1;
   logic [AB-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          err;
   logic [AB-1:0] count;
   logic          done;

   instr_encoder #(.ADDRESS_BITS(AB), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
      .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
      .mem_wEn(mem_wEn), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .err(err), .count(count), .done(done)
   );

   always #5 clock = ~clock;

   int            errors = 0;
   int            checks = 0;
   int            done_pulses = 0;
   logic [AB-1:0] exp_addr = '0;
   logic          exp_err = 1'b0;
   logic [31:0]   q_addr[$];
   logic [31:0]   q_data[$];
   logic [31:0]   wlog_addr[$];
   logic [31:0]   wlog_data[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] c, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic alt,
                                         input logic [31:0] imm, output logic e);
      logic [31:0] w;
      int          s;
      s = $signed(imm);
      e = 1'b0;
      case (c)
         4'd0: w = {7'b0, rs2, rs1, f3, rd, 7'h33} | (alt ? 32'h4000_0000 : 32'h0);
         4'd1: if (f3 == 3'd5) begin
                  w = {7'b0, imm[4:0], rs1, f3, rd, 7'h13} | (alt ? 32'h4000_0000 : 32'h0);
                  e = (imm >> 5) != 0;
               end else begin
                  w = {imm[11:0], rs1, f3, rd, 7'h13};
                  e = (s < -2048) || (s > 2047);
               end
         4'd2: begin w = {imm[11:0], rs1, f3, rd, 7'h03}; e = (s < -2048) || (s > 2047); end
         4'd3: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}; e = (s < -2048) || (s > 2047); end
         4'd4: begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
            e = (s < -4096) || (s > 4094) || imm[0];
         end
         4'd5: begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            e = (s < -1048576) || (s > 1048574) || imm[0];
         end
         4'd6: begin w = {imm[11:0], rs1, f3, rd, 7'h67}; e = (s < -2048) || (s > 2047); end
         4'd7: begin w = {imm[31:12], rd, 7'h17}; e = imm[11:0] != 0; end
         4'd8: begin w = {imm[31:12], rd, 7'h37}; e = imm[11:0] != 0; end
         default: begin w = 32'h0000_0013; e = 1'b1; end
      endcase
      return w;
   endfunction

   // Write monitor: every accepted imem write is matched against the scoreboard.
   always @(negedge clock) begin
      if (reset && done) done_pulses++;
      if (reset && mem_wEn && mem_ready) begin
         wlog_addr.push_back({16'h0, mem_addr});
         wlog_data.push_back(mem_wdata);
         if (q_data.size() == 0) check("unexpected_write", 32'd1, 32'd0);
         else begin
            check("wr_addr", {16'h0, mem_addr}, q_addr.pop_front());
            check("wr_data", mem_wdata, q_data.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                       input logic [31:0] imm);
      logic        e;
      logic [31:0] w;
      int          n;
      in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_alt = alt; in_imm = imm; in_valid = 1'b1;
      w = model(c, rd, rs1, rs2, f3, alt, imm, e);
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 200) begin
         n++;
         if (n == 3) mem_ready = 1'b1;
         @(negedge clock);
      end
      if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
      else begin
         q_data.push_back(w);
         q_addr.push_back({16'h0, exp_addr});
         exp_addr = exp_addr + 16'd4;
         if (e) exp_err = 1'b1;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q_data.size() != 0 || mem_wEn) && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) check("drain_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
   endtask

   task automatic do_start(input logic [AB-1:0] a, input logic with_flush);
      start_addr = a; start = 1'b1; flush = with_flush;
      @(posedge clock); #1;
      start = 1'b0; flush = 1'b0;
      exp_addr = {a[AB-1:2], 2'b00};
      exp_err = 1'b0;
   endtask

   task automatic do_flush();
      int d0, n;
      d0 = done_pulses;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      n = 0;
      while (done_pulses == d0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("done_after_drain", q_data.size(), 32'd0);
      repeat (4) @(negedge clock);
      check("done_once", done_pulses - d0, 32'd1);
      check("idle_in_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clock); #1;
   endtask

   initial begin
      logic [31:0] r, imm;
      logic [3:0]  c;
      int          d0;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_wen", {31'h0, mem_wEn}, 32'd0);
      check("rst_ready", {31'h0, in_ready}, 32'd0);
      check("rst_addr", {16'h0, mem_addr}, 32'd0);
      check("rst_count", {16'h0, count}, 32'd0);
      check("rst_err", {31'h0, err}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;

      // ADDI x1,x0,5 -> one-cycle latency
      do_start(16'h0100, 1'b0);
      send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
      @(negedge clock);
      check("t1_wen", {31'h0, mem_wEn}, 32'd1);
      check("t1_addr", {16'h0, mem_addr}, 32'h0100);
      check("t1_wdata", mem_wdata, 32'h0050_0093);
      @(posedge clock); #1;
      wait_idle();
      check("t1_count", {16'h0, count}, 32'd1);
      do_flush();

      // Back-to-back SUB / BEQ / JAL
      do_start(16'h0200, 1'b0);
      wlog_data.delete(); wlog_addr.delete();
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
      send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
      send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
      wait_idle();
      check("t2_nwrites", wlog_data.size(), 32'd3);
      if (wlog_data.size() == 3) begin
         check("t2_sub", wlog_data[0], 32'h4020_81B3);
         check("t2_beq", wlog_data[1], 32'h0020_8463);
         check("t2_jal", wlog_data[2], 32'h0010_00EF);
         check("t2_addr2", wlog_addr[2], 32'h0208);
      end
      check("t2_count", {16'h0, count}, 32'd3);

      // Backpressure: four fill the FIFO, fifth waits
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(4'd6, 5'(i + 1), 5'd2, 5'd0, 3'd0, 1'b0, 32'(i * 100 - 150));
      @(negedge clock);
      check("t3_full_ready", {31'h0, in_ready}, 32'd0);
      check("t3_full_wen", {31'h0, mem_wEn}, 32'd1);
      @(posedge clock); #1;
      mem_ready = 1'b1;
      @(negedge clock);
      check("t3_full_pop_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clock); #1;
      send(4'd3, 5'd0, 5'd7, 5'd9, 3'd2, 1'b0, 32'hFFFF_F800);
      wait_idle();
      check("t3_count", {16'h0, count}, 32'd8);
      check("t3_err", {31'h0, err}, 32'd0);

      // Immediate out of range is sticky
      send(4'd1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
      @(negedge clock);
      check("t4_err", {31'h0, err}, 32'd1);
      check("t4_wdata", mem_wdata, 32'h8000_0013);
      @(posedge clock); #1;
      send(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
      send(4'd9, 5'd5, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
      send(4'd1, 5'd4, 5'd3, 5'd0, 3'd5, 1'b1, 32'd7);
      wait_idle();
      check("t4_err_sticky", {31'h0, err}, 32'd1);

      // Random mix under random backpressure
      for (int i = 0; i < 24; i++) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         r = $urandom;
         c = 4'($urandom_range(0, 9));
         case ($urandom_range(0, 3))
            0:       imm = r;
            1:       imm = {r[19:0], 12'h0};
            default: imm = 32'($signed(r[12:0])) << ((c == 4'd5) ? 8 : 0);
         endcase
         send(c, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), imm);
      end
      mem_ready = 1'b1;
      wait_idle();
      check("rand_err", {31'h0, err}, {31'h0, exp_err});
      do_flush();

      // Flush outside RUN is ignored
      d0 = done_pulses;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      repeat (5) @(negedge clock);
      check("idle_flush_ignored", done_pulses - d0, 32'd0);
      @(posedge clock); #1;

      // Address wrap; start beats flush in IDLE
      do_start(16'hFFFF, 1'b1);
      @(negedge clock);
      check("t5_start_wins", {31'h0, in_ready}, 32'd1);
      check("t5_err_clr", {31'h0, err}, 32'd0);
      check("t5_count_clr", {16'h0, count}, 32'd0);
      @(posedge clock); #1;
      wlog_data.delete(); wlog_addr.delete();
      send(4'd7, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000);
      send(4'd2, 5'd11, 5'd10, 5'd0, 3'd2, 1'b0, 32'hFFFF_FFFC);
      wait_idle();
      check("t5_count", {16'h0, count}, 32'd2);
      if (wlog_addr.size() == 2) begin
         check("t5_addr0", wlog_addr[0], 32'hFFFC);
         check("t5_addr1", wlog_addr[1], 32'h0000);
      end else check("t5_nwrites", wlog_addr.size(), 32'd2);
      do_flush();

      // Reset with words queued
      do_start(16'h0040, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(4'd1, 5'(i), 5'(i), 5'd0, 3'd0, 1'b0, 32'(i));
      reset = 1'b0;
      @(posedge clock); #1;
      q_data.delete(); q_addr.delete();
      @(negedge clock);
      check("t6_wen", {31'h0, mem_wEn}, 32'd0);
      check("t6_count", {16'h0, count}, 32'd0);
      check("t6_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      mem_ready = 1'b1;
      repeat (6) @(negedge clock);
      check("t6_no_writes", {31'h0, mem_wEn}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
